// File: rtl/ram_64x8_pkg.sv
// Shared constants and types for the 64x8 single-port scratch RAM.
package ram_64x8_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/ram_64x8_if.sv
// Access bus of the RAM: write enable, shared address, write data, read data.
interface ram_64x8_if
    import ram_64x8_pkg::*;
    ();

    logic  wen;
    addr_t addr;
    word_t din;
    word_t dout;

    modport master (output wen, output addr, output din, input dout);
    modport slave  (input wen, input addr, input din, output dout);

endinterface

// File: rtl/ram_64x8_array.sv
// Flip-flop storage array with per-word asynchronous clear and write decode.
// The addressed word is presented combinationally; the caller registers it.
module ram_64x8_array
    import ram_64x8_pkg::*;
    (
    input  logic  ck,
    input  logic  rst_n,
    input  logic  we,
    input  addr_t addr,
    input  word_t wdata,
    output word_t rdata
);

    word_t mem_q [DEPTH];
    word_t mem_d [DEPTH];

    // Next contents: only the addressed word changes, and only when writing.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[addr] = wdata;
        end
    end

    // Storage flops; reset clears every word regardless of the clock.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/ram_64x8.sv
// 64x8 single-port synchronous RAM with registered, write-first read data.
module ram_64x8
    import ram_64x8_pkg::*;
    (
    input  logic       ck,
    input  logic       rst_n,
    ram_64x8_if.slave  bus
);

    word_t rd_word;
    word_t dout_d;
    word_t dout_q;

    ram_64x8_array u_array (
        .ck    (ck),
        .rst_n (rst_n),
        .we    (bus.wen),
        .addr  (bus.addr),
        .wdata (bus.din),
        .rdata (rd_word)
    );

    // Write-first: a write to the addressed word bypasses the stored value.
    always_comb begin
        dout_d = rd_word;
        if (bus.wen) begin
            dout_d = bus.din;
        end
    end

    // Read register; cleared asynchronously together with the array.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign bus.dout = dout_q;

endmodule

// File: tb/tb_ram_64x8.sv
// Scoreboard bench for ram_64x8: driver pushes expected read data computed
// from a plain array model, monitor pops and compares after each rising edge.
module tb_ram_64x8;

    logic ck;
    logic rst_n;

    ram_64x8_if bus_if ();

    ram_64x8 dut (
        .ck    (ck),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    typedef struct {
        string      name;
        logic [5:0] addr;
        logic [7:0] exp;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ref_mem [64];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    endtask

    // One bus cycle: drive at the falling edge, predict the value dout takes
    // at the following rising edge.
    task automatic do_cycle(input string name, input logic w, input logic [5:0] a,
                            input logic [7:0] d);
        exp_t e;
        @(negedge ck);
        bus_if.wen  = w;
        bus_if.addr = a;
        bus_if.din  = d;
        if (w) ref_mem[a] = d;
        e.name = name;
        e.addr = a;
        e.exp  = ref_mem[a];
        exp_q.push_back(e);
    endtask

    // Monitor: dout is registered, so every edge out of reset presents a result.
    initial begin
        exp_t e;
        forever begin
            @(posedge ck);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("%s@%0d", e.name, e.addr), bus_if.dout, e.exp);
            end
        end
    end

    initial begin
        logic [7:0] vals [8];
        vals = '{8'd2, 8'd3, 8'd5, 8'd7, 8'd11, 8'd13, 8'd17, 8'd19};

        rst_n       = 1'b0;
        bus_if.wen  = 1'b0;
        bus_if.addr = '0;
        bus_if.din  = '0;
        model_clear();

        // Reset held for two cycles
        repeat (2) @(posedge ck);
        #1 check("reset_dout", bus_if.dout, 8'h00);
        @(negedge ck);
        rst_n = 1'b1;

        for (int a = 0; a < 64; a++) do_cycle("rst_sweep", 1'b0, 6'(a), 8'h00);

        // Back-to-back writes then idle
        for (int i = 0; i < 4; i++) do_cycle("wr_lo", 1'b1, 6'(i), vals[i]);
        for (int i = 0; i < 4; i++) do_cycle("wr_hi", 1'b1, 6'(16 + i), vals[4 + i]);
        repeat (10) do_cycle("idle", 1'b0, 6'd0, 8'h00);
        for (int a = 0; a < 64; a++) do_cycle("rd_sweep", 1'b0, 6'(a), 8'h00);

        // Write-first and later read-back
        do_cycle("wfirst", 1'b1, 6'd5, 8'hA5);
        do_cycle("wfirst_rd", 1'b0, 6'd5, 8'h00);

        // Overwrite at top address, bottom address unaffected
        do_cycle("ovw_ff", 1'b1, 6'd63, 8'hFF);
        do_cycle("ovw_01", 1'b1, 6'd63, 8'h01);
        do_cycle("ovw_rd", 1'b0, 6'd63, 8'h00);
        do_cycle("addr0_rd", 1'b0, 6'd0, 8'h00);

        // Read register hold across addr changes with no edge
        do_cycle("hold_rd", 1'b0, 6'd16, 8'h00);
        @(posedge ck);
        #2;
        for (int i = 0; i < 4; i++) begin
            bus_if.addr = 6'(i);
            #1 check("hold", bus_if.dout, 8'd11);
        end

        // Asynchronous reset between edges; write during reset is lost
        for (int i = 0; i < 4; i++) do_cycle("reload", 1'b1, 6'(i), vals[i] + 8'h40);
        @(negedge ck);
        bus_if.wen  = 1'b1;
        bus_if.addr = 6'd2;
        bus_if.din  = 8'h77;
        #2 rst_n = 1'b0;
        model_clear();
        #1 check("async_clr", bus_if.dout, 8'h00);
        @(posedge ck);
        #1 check("rst_low_edge", bus_if.dout, 8'h00);
        @(negedge ck);
        bus_if.wen = 1'b0;
        rst_n      = 1'b1;
        for (int a = 0; a < 4; a++) do_cycle("post_rst", 1'b0, 6'(a), 8'h00);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            do_cycle("rand", 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                     8'($urandom_range(0, 255)));
        end
        for (int a = 0; a < 64; a++) do_cycle("final_sweep", 1'b0, 6'(a), 8'h00);

        // Drain: every prediction must have been consumed
        repeat (2) @(posedge ck);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_64x8.md
# ram_64x8

Single-port synchronous RAM: 64 words of 8 bits, one clock, one shared address bus for read and write. It serves as a small general-purpose scratch store for datapath blocks. An asynchronous active-low reset clears the whole array and the read register, so the block powers up in a known all-zero state.

## Interface

Parameters:
- DATA_W, 8, word width in bits
- ADDR_W, 6, address width in bits
- DEPTH, 64, number of words; must equal 2**ADDR_W

Ports:
- ck  input  1  clock; all state changes on the rising edge except reset
- rst_n  input  1  reset, asynchronous, active-low; clears memory and dout
- wen  input  1  write enable, active-high
- addr  input  ADDR_W  word address, used for both write and read
- din  input  DATA_W  write data
- dout  output  DATA_W  registered read data

## Operation

- Reset (rst_n=0): all 64 locations = 8'h00, dout = 8'h00, immediately and independent of ck. While rst_n is low, writes and reads are ignored.
- Write: on a rising ck edge with wen=1 and rst_n=1, mem[addr] <= din.
- Read: on every rising ck edge with rst_n=1, dout <= mem[addr].
- Same-edge write and read at one address: write-first. dout <= din, and the new value is stored.
- Write-enable cycles do not suppress the read path. dout always reflects the addressed location per the rule above.
- dout holds its value between edges. It never changes combinationally with addr.
- Address space is exactly 64 entries. There is no out-of-range condition, and every addr value is valid.
- X on wen while out of reset: no requirement. The bench must not drive X.

## Timing

- Write latency: data is stored at the first rising edge where wen=1. It is readable on dout after the next rising edge with that address, or at the same edge through write-first.
- Read latency: 1 cycle. An addr applied before edge N appears on dout after edge N.
- Inputs addr, din and wen are sampled only at the rising edge. They may change anywhere else in the cycle.
- Reset assertion mid-operation:
  - Contents and dout clear asynchronously.
  - A write coinciding with the reset edge is lost.
- Reset deassertion: the first rising edge with rst_n=1 performs normal read/write.
- Back-to-back writes to consecutive addresses, one per cycle, are supported with no bubbles.

## Structure

- Shared package ram_64x8_pkg holds the constants DATA_W, ADDR_W and DEPTH, plus the typedef word_t (logic [DATA_W-1:0]).
- One sub-module, ram_64x8_array:
  - Contains the storage array, with per-word async clear and write decode.
  - The top level holds the dout register and the write-first mux.
- Storage is flip-flop based because of the async clear requirement. No inferred block RAM.

## Test plan

- Reset: drive rst_n=0 for 2 cycles, then release. Sweep addr 0..63 with wen=0 -> dout=8'h00 at every address, one cycle after each addr.
- Writes and read-back:
  - Write 2,3,5,7 at addr 0..3 and 11,13,17,19 at addr 16..19, one per cycle. Wait 10 idle cycles.
  - Sweep addr 0..63 -> dout returns those values at the matching addresses and 0 elsewhere, with 1-cycle latency.
- Write-first: write 8'hA5 to addr 5 while reading addr 5 on the same edge -> dout=8'hA5 after that edge. A later read of addr 5 returns 8'hA5.
- Overwrite and boundary:
  - Write 8'hFF to addr 63, then 8'h01 to addr 63 -> read gives 8'h01.
  - Addr 0 stays unaffected.
- Async reset mid-operation:
  - After loading addr 0..3, pulse rst_n low between clock edges -> dout=0 immediately.
  - The subsequent sweep of addr 0..3 reads 0.
  - A write attempted while rst_n=0 is not stored.
- Read register hold: keep addr=16 (value 11), then toggle addr between edges without a clock edge -> dout stays 11 until the next rising edge.
